// File: rtl/rx_fifo_pkg.sv
// Shared UART-wide defaults for the receive FIFO and its storage array.
package rx_fifo_pkg;

  localparam int DATA_LENGTH        = 8;
  localparam int RX_FIFO_ADDR_WIDTH = 4;

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import rx_fifo_pkg::*;
#(
  parameter int DATA_LENGTH = rx_fifo_pkg::DATA_LENGTH,
  parameter int ADDR_WIDTH  = RX_FIFO_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATA_LENGTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [DATA_LENGTH-1:0] rdata
);

  logic [DATA_LENGTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately not reset; the FIFO masks the head when empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver: pointers, flags, sticky overflow.
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int DATA_LENGTH = rx_fifo_pkg::DATA_LENGTH,
  parameter int ADDR_WIDTH  = RX_FIFO_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [DATA_LENGTH-1:0] wr_data,
  input  logic                   rd_en,
  output logic [DATA_LENGTH-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_WIDTH:0]    count,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [ADDR_WIDTH:0]    wr_ptr;
  logic [ADDR_WIDTH:0]    rd_ptr;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [DATA_LENGTH-1:0] head;

  // Flags come only from the registered pointers; MSB is the wrap bit.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count = wr_ptr - rd_ptr;

  // A pop frees the slot a same-cycle push at full needs; no bypass when empty.
  assign pop  = rd_en && !empty;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && !push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_LENGTH (DATA_LENGTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (head)
  );

  assign rd_data = empty ? '0 : head;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: vector table plus hand-written multi-cycle sequences.
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  rx_fifo dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic       e_empty;
    logic       e_full;
    logic [4:0] e_count;
    logic       e_ovf;
    logic [7:0] e_rd_data;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    overflow_clr = c;
  endtask

  task automatic chk_all(input string tag, input logic e, input logic f, input int c,
                         input logic o, input int rdv);
    chk({tag, ".empty"}, empty, e);
    chk({tag, ".full"}, full, f);
    chk({tag, ".count"}, count, c);
    chk({tag, ".overflow"}, overflow, o);
    chk({tag, ".rd_data"}, rd_data, rdv);
  endtask

  int q[$];
  int exp_head;
  logic w, r, pop_ok, push_ok;
  logic [7:0] d;

  initial begin
    //            wr data   rd clr  empty full cnt ovf rd_data
    vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'h11};
    vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 8'h11};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'h22};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};

    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h5A + 8'(i), i[0], i[1]);
      step();
    end
    chk_all("reset", 1'b1, 1'b0, 0, 1'b0, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full, vecs[i].e_count,
              vecs[i].e_ovf, vecs[i].e_rd_data);
    end

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      step();
    end
    chk_all("fill", 1'b0, 1'b1, 16, 1'b0, 8'h00);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    step();
    chk_all("drop", 1'b0, 1'b1, 16, 1'b1, 8'h00);
    drive(1'b1, 8'hFF, 1'b0, 1'b1);
    step();
    chk("drop_clr.overflow", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), rd_data, i);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end
    chk_all("drained", 1'b1, 1'b0, 0, 1'b1, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("clr.overflow", overflow, 0);

    // Simultaneous read and write at full
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    step();
    chk_all("full_rw", 1'b0, 1'b1, 16, 1'b0, 8'h01);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rw_drain%0d", i), rd_data, (i < 15) ? i + 1 : 8'h55);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end
    chk("rw_drain.empty", empty, 1);

    // Wrap-around: write, write, read pattern against a queue model
    q.delete();
    for (int i = 0; i < 60; i++) begin
      w = (i < 40) && ((i % 3) != 2);
      r = (i >= 40) || ((i % 3) == 2);
      d = 8'(i * 7 + 3);
      drive(w, d, r, 1'b0);
      step();
      pop_ok = r && (q.size() > 0);
      if (pop_ok) void'(q.pop_front());
      push_ok = w && (q.size() < 16);
      if (push_ok) q.push_back(int'(d));
      exp_head = (q.size() > 0) ? q[0] : 0;
      chk($sformatf("wrap%0d.count", i), count, q.size());
      chk($sformatf("wrap%0d.rd_data", i), rd_data, exp_head);
    end
    chk("wrap.empty", empty, 1);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      step();
    end
    chk("pre_rst.count", count, 5);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst.empty", empty, 1);
    chk("mid_rst.count", count, 0);
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk_all("post_rst", 1'b1, 1'b0, 0, 1'b0, 0);
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("post_rst_wr", 1'b0, 1'b0, 1, 1'b0, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
